// File: rtl/hps_ext_master.sv
// Host-side master for a strobed 16-bit external bus: one command word, then len data
// words. Each data strobe is followed by a gap whose last cycle captures the responder word.
module hps_ext_master #(
    parameter int STROBE_GAP = 2,
    parameter int IDLE_GAP   = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_cmd,
    input  logic [9:0]  req_len,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        nack,
    output logic        busy,
    output logic [15:0] ext_io_din,
    output logic        ext_strobe,
    output logic        ext_enable,
    input  logic [15:0] ext_io_dout,
    input  logic        ext_dout_en
);

    typedef enum logic [3:0] {
        IDLE, SETUP, CMD, CMD_GAP, DATA_WAIT, DATA_STROBE, DATA_GAP, FINISH, COOLDOWN
    } state_t;

    localparam logic [3:0] SG_LAST = 4'(STROBE_GAP - 1);
    localparam logic [3:0] IG_LAST = 4'(IDLE_GAP - 1);

    state_t      state;
    logic [15:0] cmd_q;
    logic [9:0]  len_q;
    logic [9:0]  cnt;
    logic [3:0]  gap;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            cmd_q      <= '0;
            len_q      <= '0;
            cnt        <= '0;
            gap        <= '0;
            req_ready  <= 1'b1;
            wr_ready   <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            nack       <= 1'b0;
            busy       <= 1'b0;
            ext_io_din <= '0;
            ext_strobe <= 1'b0;
            ext_enable <= 1'b0;
        end else begin
            // Pulse-type outputs default low; din must be zero whenever strobe is low.
            ext_strobe <= 1'b0;
            ext_io_din <= '0;
            wr_ready   <= 1'b0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            nack       <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cmd_q      <= req_cmd;
                        len_q      <= req_len;
                        cnt        <= '0;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        ext_enable <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    ext_strobe <= 1'b1;
                    ext_io_din <= cmd_q;
                    state      <= CMD;
                end
                CMD: begin
                    gap   <= '0;
                    state <= CMD_GAP;
                end
                CMD_GAP: begin
                    if (gap == SG_LAST) begin
                        if (!ext_dout_en || len_q == 10'd0) begin
                            ext_enable <= 1'b0;
                            done       <= 1'b1;
                            nack       <= ~ext_dout_en;
                            state      <= FINISH;
                        end else begin
                            state <= DATA_WAIT;
                        end
                    end else begin
                        gap <= gap + 4'd1;
                    end
                end
                DATA_WAIT: begin
                    if (wr_valid) begin
                        ext_strobe <= 1'b1;
                        ext_io_din <= wr_data;
                        wr_ready   <= 1'b1;
                        state      <= DATA_STROBE;
                    end
                end
                DATA_STROBE: begin
                    cnt   <= cnt + 10'd1;
                    gap   <= '0;
                    state <= DATA_GAP;
                end
                DATA_GAP: begin
                    if (gap == SG_LAST) begin
                        rd_data  <= ext_io_dout;
                        rd_valid <= 1'b1;
                        if (cnt == len_q) begin
                            ext_enable <= 1'b0;
                            done       <= 1'b1;
                            state      <= FINISH;
                        end else begin
                            state <= DATA_WAIT;
                        end
                    end else begin
                        gap <= gap + 4'd1;
                    end
                end
                FINISH: begin
                    gap   <= '0;
                    state <= COOLDOWN;
                end
                COOLDOWN: begin
                    if (gap == IG_LAST) begin
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        gap <= gap + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hps_ext_master.sv
// Directed bench for hps_ext_master: a negedge monitor logs bus activity and acts as the
// responder (returns 0x00A0 + word index); the initial block runs scenarios and checks deltas.
module tb_hps_ext_master;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_cmd = '0;
    logic [9:0]  req_len = '0;
    logic [15:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        nack;
    logic        busy;
    logic [15:0] ext_io_din;
    logic        ext_strobe;
    logic        ext_enable;
    logic [15:0] ext_io_dout = '0;
    logic        ext_dout_en = 1'b1;

    always #5 clk_sys = ~clk_sys;

    hps_ext_master #(.STROBE_GAP(2), .IDLE_GAP(2)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .nack(nack), .busy(busy),
        .ext_io_din(ext_io_din), .ext_strobe(ext_strobe), .ext_enable(ext_enable),
        .ext_io_dout(ext_io_dout), .ext_dout_en(ext_dout_en)
    );

    int ntests = 0;
    int nfail  = 0;

    // Monitor / responder state (written only by the negedge process)
    int          n_strobe = 0, n_wr = 0, n_rd = 0, n_done = 0, n_nack = 0, n_en = 0;
    int          viol = 0, low_run = 0, last_low = 0, cyc = 0, last_st = 0, scnt = 0;
    logic        prev_st = 1'b0;
    logic [15:0] rd_log [256];
    logic [15:0] din_log [256];
    int          sp_log [256];

    always @(negedge clk_sys) begin
        cyc++;
        if (ext_strobe && !ext_enable) viol++;
        if (ext_strobe && prev_st) viol++;
        if (!ext_strobe && ext_io_din != 16'h0) viol++;
        if (wr_ready && !ext_strobe) viol++;
        prev_st = ext_strobe;
        if (ext_strobe) begin
            din_log[8'(n_strobe)] = ext_io_din;
            sp_log[8'(n_strobe)]  = (scnt == 0) ? 0 : cyc - last_st;
            last_st = cyc;
            n_strobe++;
            if (scnt > 0) ext_io_dout = 16'h00A0 + 16'(scnt - 1);
            scnt++;
        end
        if (!ext_enable) scnt = 0;
        if (wr_ready) n_wr++;
        if (rd_valid) begin
            rd_log[8'(n_rd)] = rd_data;
            n_rd++;
        end
        if (done) n_done++;
        if (done && nack) n_nack++;
        if (ext_enable) begin
            n_en++;
            if (low_run > 0) last_low = low_run;
            low_run = 0;
        end else begin
            low_run++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          stall_bad = 0, stall_lat = 0;
    logic [15:0] stall_din = '0;

    task automatic run_txn(input logic [15:0] cmd, input logic [9:0] len,
                           input int stall_at, input int stall_n);
        int   t;
        logic got_done;
        t = 0;
        while (req_ready !== 1'b1 && t < 100) begin @(posedge clk_sys); #1; t++; end
        req_cmd = cmd; req_len = len; req_valid = 1'b1;
        @(posedge clk_sys); #1;
        req_valid = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < int'(len) && !got_done; i++) begin
            if (i == stall_at) begin
                repeat (stall_n) begin
                    @(posedge clk_sys); #1;
                    if (ext_strobe || !ext_enable) stall_bad++;
                end
            end
            wr_data  = 16'h1111 * 16'(i + 1);
            wr_valid = 1'b1;
            t = 0;
            do begin
                @(posedge clk_sys); #1; t++;
                if (done) got_done = 1'b1;
            end while (!wr_ready && !got_done && t < 100);
            if (i == stall_at) begin
                stall_lat = t;
                stall_din = ext_io_din;
            end
            wr_valid = 1'b0;
        end
        t = 0;
        while (!got_done && t < 100) begin
            @(posedge clk_sys); #1; t++;
            if (done) got_done = 1'b1;
        end
        chk("txn_done_seen", 32'(got_done), 32'd1);
    endtask

    int s_strobe, s_wr, s_rd, s_done, s_nack, s_en, t;

    task automatic snap();
        s_strobe = n_strobe; s_wr = n_wr; s_rd = n_rd;
        s_done = n_done; s_nack = n_nack; s_en = n_en;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_ctrl", 32'({req_ready, wr_ready, rd_valid, done, nack, busy, ext_strobe, ext_enable}),
            32'h80);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_din", 32'(ext_io_din), 32'h0);
        reset = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("idle_after_rst", 32'({req_ready, busy, ext_enable}), 32'b100);

        // Scenario 1: len=0
        ext_dout_en = 1'b1;
        snap();
        run_txn(16'h0034, 10'd0, -1, 0);
        chk("s1_done_nack", 32'({done, nack}), 32'b10);
        repeat (4) @(posedge clk_sys);
        #1;
        chk("s1_enable_cycles", 32'(n_en - s_en), 32'd4);
        chk("s1_strobes", 32'(n_strobe - s_strobe), 32'd1);
        chk("s1_cmd_din", 32'(din_log[8'(s_strobe)]), 32'h0034);
        chk("s1_done_cnt", 32'(n_done - s_done), 32'd1);
        chk("s1_rd_valid", 32'(n_rd - s_rd), 32'd0);
        chk("s1_wr_ready", 32'(n_wr - s_wr), 32'd0);

        // Scenario 2: len=3
        snap();
        run_txn(16'h0035, 10'd3, -1, 0);
        chk("s2_done_nack", 32'({done, nack}), 32'b10);
        repeat (4) @(posedge clk_sys);
        #1;
        chk("s2_strobes", 32'(n_strobe - s_strobe), 32'd4);
        chk("s2_cmd_din", 32'(din_log[8'(s_strobe)]), 32'h0035);
        chk("s2_din_w3", 32'(din_log[8'(s_strobe + 3)]), 32'h3333);
        chk("s2_wr_ready", 32'(n_wr - s_wr), 32'd3);
        chk("s2_rd_cnt", 32'(n_rd - s_rd), 32'd3);
        chk("s2_rd0", 32'(rd_log[8'(s_rd)]), 32'h00A0);
        chk("s2_rd1", 32'(rd_log[8'(s_rd + 1)]), 32'h00A1);
        chk("s2_rd2", 32'(rd_log[8'(s_rd + 2)]), 32'h00A2);
        for (int k = 1; k <= 3; k++)
            chk("s2_strobe_spacing", 32'(sp_log[8'(s_strobe + k)]), 32'd4);
        chk("s2_nack_cnt", 32'(n_nack - s_nack), 32'd0);

        // Scenario 3: responder refuses
        ext_dout_en = 1'b0;
        snap();
        run_txn(16'h0010, 10'd5, -1, 0);
        chk("s3_done_nack", 32'({done, nack}), 32'b11);
        repeat (4) @(posedge clk_sys);
        #1;
        chk("s3_strobes", 32'(n_strobe - s_strobe), 32'd1);
        chk("s3_cmd_din", 32'(din_log[8'(s_strobe)]), 32'h0010);
        chk("s3_wr_ready", 32'(n_wr - s_wr), 32'd0);
        chk("s3_rd_valid", 32'(n_rd - s_rd), 32'd0);
        chk("s3_nack_cnt", 32'(n_nack - s_nack), 32'd1);

        // Scenario 4: 7-cycle stall before word 2
        ext_dout_en = 1'b1;
        stall_bad = 0;
        snap();
        run_txn(16'h0044, 10'd2, 1, 7);
        repeat (4) @(posedge clk_sys);
        #1;
        chk("s4_stall_quiet", 32'(stall_bad), 32'd0);
        chk("s4_strobe_latency", 32'(stall_lat), 32'd1);
        chk("s4_word2_din", 32'(stall_din), 32'h2222);
        chk("s4_wr_ready", 32'(n_wr - s_wr), 32'd2);
        chk("s4_rd1", 32'(rd_log[8'(s_rd + 1)]), 32'h00A1);

        // Scenario 5: reset in DATA_GAP of word 1
        t = 0;
        while (req_ready !== 1'b1 && t < 100) begin @(posedge clk_sys); #1; t++; end
        snap();
        req_cmd = 16'h0040; req_len = 10'd2; req_valid = 1'b1;
        @(posedge clk_sys); #1;
        req_valid = 1'b0;
        wr_data = 16'h5555; wr_valid = 1'b1;
        t = 0;
        do begin @(posedge clk_sys); #1; t++; end while (!wr_ready && t < 100);
        chk("s5_word1_taken", 32'(wr_ready), 32'd1);
        wr_valid = 1'b0;
        @(posedge clk_sys); #1;
        reset = 1'b1;
        @(posedge clk_sys); #1;
        chk("s5_after_reset", 32'({ext_enable, busy, req_ready, done}), 32'b0010);
        reset = 1'b0;
        s_en = n_en;
        repeat (6) @(posedge clk_sys);
        #1;
        chk("s5_no_done", 32'(n_done - s_done), 32'd0);
        chk("s5_no_rd_valid", 32'(n_rd - s_rd), 32'd0);
        chk("s5_request_dropped", 32'(n_en - s_en), 32'd0);

        // Scenario 6: req_valid held across done
        snap();
        req_cmd = 16'h0021; req_len = 10'd0; req_valid = 1'b1;
        t = 0;
        do begin @(posedge clk_sys); #1; t++; end while (!done && t < 100);
        chk("s6_done1", 32'(done), 32'd1);
        req_cmd = 16'h0022;
        t = 0;
        do begin @(posedge clk_sys); #1; t++; end while (req_ready !== 1'b1 && t < 100);
        chk("s6_ready_latency", 32'(t), 32'd3);
        @(posedge clk_sys); #1;
        chk("s6_accepted", 32'({req_ready, ext_enable}), 32'b01);
        req_valid = 1'b0;
        t = 0;
        do begin @(posedge clk_sys); #1; t++; end while (!done && t < 100);
        chk("s6_done2", 32'(done), 32'd1);
        repeat (4) @(posedge clk_sys);
        #1;
        chk("s6_strobes", 32'(n_strobe - s_strobe), 32'd2);
        chk("s6_cmd1_din", 32'(din_log[8'(s_strobe)]), 32'h0021);
        chk("s6_cmd2_din", 32'(din_log[8'(s_strobe + 1)]), 32'h0022);
        chk("s6_enable_low_gap", 32'(last_low), 32'd4);
        chk("s6_idle_after", 32'({req_ready, busy}), 32'b10);

        chk("bus_rule_violations", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
